// File: rtl/tetris_pkg.sv
// ----------------------------------------------------------------------------
// tetris_pkg: board geometry, cell codes and sprite block types.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tetris_pkg;

  localparam int CELL_PX    = 16;
  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;

  typedef logic [3:0] cell_code_t;

  typedef enum logic [2:0] {
    GHOST = 3'd0,
    I     = 3'd1,
    L     = 3'd2,
    J     = 3'd3,
    T     = 3'd4,
    S     = 3'd5,
    Z     = 3'd6,
    O     = 3'd7
  } block_type_t;

  localparam cell_code_t  CELL_GHOST = 4'd8;
  localparam cell_code_t  CELL_EMPTY = 4'd0;
  localparam logic [23:0] GRID_COLOR = 24'h202020;

  function automatic logic is_piece(cell_code_t code);
    return (code >= 4'd1) && (code <= 4'd7);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tetris_block_fetch_if.sv
// ----------------------------------------------------------------------------
// tetris_block_fetch_if: pixel, board-memory and sprite-ROM signals of the fetch.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface tetris_block_fetch_if;
  import tetris_pkg::*;

  logic        pix_valid_in;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [3:0]  cell_col;
  logic [4:0]  cell_row;
  cell_code_t  cell_code;
  logic [9:0]  rom_addr;
  block_type_t rom_type;
  logic [23:0] rom_data;
  logic [23:0] rgb_out;
  logic        pix_valid_out;
  logic        in_board_out;

  modport master (
    output pix_valid_in, DrawX, DrawY, cell_code, rom_data,
    input  cell_col, cell_row, rom_addr, rom_type, rgb_out, pix_valid_out, in_board_out
  );

  modport slave (
    input  pix_valid_in, DrawX, DrawY, cell_code, rom_data,
    output cell_col, cell_row, rom_addr, rom_type, rgb_out, pix_valid_out, in_board_out
  );

endinterface

`default_nettype wire

// File: rtl/tetris_cell_decode.sv
// ----------------------------------------------------------------------------
// tetris_cell_decode: board cell code -> sprite block type and empty flag.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tetris_cell_decode
  import tetris_pkg::*;
(
  input  cell_code_t  cell_code,
  output block_type_t rom_type,
  output logic        empty
);

  // Ghost shares sprite type 0 but is drawn; CELL_EMPTY and 9..15 are blank.
  always_comb begin
    rom_type = GHOST;
    empty    = 1'b1;
    if (is_piece(cell_code)) begin
      rom_type = block_type_t'(cell_code[2:0]);
      empty    = 1'b0;
    end else if (cell_code == CELL_GHOST) begin
      empty    = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tetris_block_fetch.sv
// ----------------------------------------------------------------------------
// tetris_block_fetch: 3-clock pixel -> board cell -> sprite ROM -> colour pipe.
// Optional grid overlay on empty cells: define TETRIS_GRID_LINES_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tetris_block_fetch
  import tetris_pkg::*;
#(
  parameter logic [9:0]  BOARD_X0    = 10'd240,
  parameter logic [9:0]  BOARD_Y0    = 10'd80,
  parameter logic [23:0] BG_COLOR    = 24'h000000,
  parameter logic [23:0] TRANSPARENT = 24'hFF00FF
)(
  input  logic               Clk,
  input  logic               Reset,
  tetris_block_fetch_if.slave bus
);

  localparam logic [9:0] BOARD_W = 10'(BOARD_COLS * CELL_PX);
  localparam logic [9:0] BOARD_H = 10'(BOARD_ROWS * CELL_PX);

  logic [9:0]  dx;
  logic [9:0]  dy;
  logic        inb;

  logic        valid1;
  logic        inb1;
  logic [3:0]  xo1;
  logic [3:0]  yo1;

  block_type_t cell_type;
  logic        cell_empty;

  logic        valid2;
  logic        inb2;
  logic        empty2;
`ifdef TETRIS_GRID_LINES_EN
  logic [3:0]  xo2;
  logic [3:0]  yo2;
`endif

  logic [23:0] rgb_next;

  // Unsigned wrap makes pixels left of / above the board fail the range test.
  assign dx  = bus.DrawX - BOARD_X0;
  assign dy  = bus.DrawY - BOARD_Y0;
  assign inb = (dx < BOARD_W) && (dy < BOARD_H);

  assign bus.cell_col = inb ? dx[7:4] : 4'd0;
  assign bus.cell_row = inb ? dy[8:4] : 5'd0;

  tetris_cell_decode u_decode (
    .cell_code (bus.cell_code),
    .rom_type  (cell_type),
    .empty     (cell_empty)
  );

  assign bus.rom_addr = inb1 ? {2'b00, yo1, xo1} : 10'd0;
  assign bus.rom_type = inb1 ? cell_type : GHOST;

  always_comb begin
    rgb_next = bus.rom_data;
    if (!inb2) begin
      rgb_next = BG_COLOR;
    end else if (empty2) begin
`ifdef TETRIS_GRID_LINES_EN
      rgb_next = ((xo2 == 4'd0) || (yo2 == 4'd0)) ? GRID_COLOR : BG_COLOR;
`else
      rgb_next = BG_COLOR;
`endif
    end else if (bus.rom_data == TRANSPARENT) begin
      rgb_next = BG_COLOR;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid1            <= 1'b0;
      inb1              <= 1'b0;
      xo1               <= 4'd0;
      yo1               <= 4'd0;
      valid2            <= 1'b0;
      inb2              <= 1'b0;
      empty2            <= 1'b0;
`ifdef TETRIS_GRID_LINES_EN
      xo2               <= 4'd0;
      yo2               <= 4'd0;
`endif
      bus.rgb_out       <= 24'd0;
      bus.pix_valid_out <= 1'b0;
      bus.in_board_out  <= 1'b0;
    end else begin
      valid1            <= bus.pix_valid_in;
      inb1              <= inb;
      xo1               <= dx[3:0];
      yo1               <= dy[3:0];
      valid2            <= valid1;
      inb2              <= inb1;
      empty2            <= cell_empty;
`ifdef TETRIS_GRID_LINES_EN
      xo2               <= xo1;
      yo2               <= yo1;
`endif
      bus.rgb_out       <= rgb_next;
      bus.pix_valid_out <= valid2;
      bus.in_board_out  <= inb2;
    end
  end

endmodule

`default_nettype wire
